// File: rtl/segmentos_a_binario.sv
`default_nettype none
// ============================================================================
// Module   : segmentos_a_binario
// Purpose  : Rebuilds a binary value from a frame of NUM_DIGITS 7-segment
//            digit patterns, most significant digit first. Flags illegal
//            patterns and saturates results wider than VALUE_W bits.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            seg_in     - segment pattern {a,b,c,d,e,f,g}, active high
//            seg_valid  - seg_in carries a digit
//            seg_ready  - a digit is accepted this cycle
//            value_out  - reconstructed value (all ones on overflow)
//            err_out    - frame contained at least one illegal pattern
//            ovf_out    - frame value did not fit in VALUE_W bits
//            out_valid  - result outputs are valid
//            out_ready  - consumer takes the result
// Options  : SEGMENTOS_BLANK_EN - when defined, the blank pattern 0000000
//            is a legal digit 0 (leading-zero suppression).
// Revision : 1.0 - initial release
// ============================================================================
module segmentos_a_binario #(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         seg_in,
  input  logic               seg_valid,
  output logic               seg_ready,
  output logic [VALUE_W-1:0] value_out,
  output logic               err_out,
  output logic               ovf_out,
  output logic               out_valid,
  input  logic               out_ready
);

  // A BCD-sized accumulator always holds 10^NUM_DIGITS-1, so it never wraps.
  localparam int ACC_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  // Overflow compare is done in a width that holds both the accumulator and
  // the output limit, whichever is wider.
  localparam int EXT_W = ((ACC_W > VALUE_W) ? ACC_W : VALUE_W) + 1;
  localparam logic [EXT_W-1:0] LIMIT = (EXT_W'(1) << VALUE_W) - EXT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               err_sticky;

  logic [3:0]         digit;
  logic               illegal;
  logic [ACC_W-1:0]   acc_mac;
  logic [EXT_W-1:0]   acc_ext;
  logic               over_limit;
  logic               accept;
  logic               last_digit;
  logic               release_out;

  // Pattern decode; unknown patterns contribute 0 and raise the error.
  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    case (seg_in)
      7'b1111110: digit = 4'd0;
      7'b0110000: digit = 4'd1;
      7'b1101101: digit = 4'd2;
      7'b1111001: digit = 4'd3;
      7'b0110011: digit = 4'd4;
      7'b1011011: digit = 4'd5;
      7'b1011111: digit = 4'd6;
      7'b1110000: digit = 4'd7;
      7'b1111111: digit = 4'd8;
      7'b1111011: digit = 4'd9;
`ifdef SEGMENTOS_BLANK_EN
      7'b0000000: digit = 4'd0;
`endif
      default:    illegal = 1'b1;
    endcase
  end

  // acc*10 + digit written as shifts to keep the multiply cheap.
  assign acc_mac     = (acc << 3) + (acc << 1) + ACC_W'(digit);
  assign acc_ext     = EXT_W'(acc_mac);
  assign over_limit  = (acc_ext > LIMIT);
  assign accept      = seg_valid && seg_ready;
  assign last_digit  = accept && (count == LAST_IDX);
  assign release_out = out_valid && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (last_digit)  state_next = HOLD;
      HOLD:    if (release_out) state_next = COLLECT;
      default:                  state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Handshake flags follow the next state so both stay registered; after
  // reset seg_ready comes up on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_ready <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      seg_ready <= (state_next == COLLECT);
      out_valid <= (state_next == HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
      value_out  <= '0;
      err_out    <= 1'b0;
      ovf_out    <= 1'b0;
    end else begin
      if ((state == COLLECT) && accept) begin
        acc        <= acc_mac;
        count      <= count + CNT_W'(1);
        err_sticky <= err_sticky | illegal;
        if (last_digit) begin
          value_out <= over_limit ? {VALUE_W{1'b1}} : VALUE_W'(acc_mac);
          ovf_out   <= over_limit;
          err_out   <= err_sticky | illegal;
        end
      end
      // Frame state clears on result acceptance; result registers keep
      // their last contents while out_valid is low.
      if ((state == HOLD) && release_out) begin
        acc        <= '0;
        count      <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segmentos_a_binario.sv
`default_nettype none
// ============================================================================
// Module   : tb_segmentos_a_binario
// Purpose  : Self-checking bench for segmentos_a_binario (3 digits, 8 bits).
//            Table of directed frames, handshake/reset corner sequences and
//            random frames compared with a behavioural reference model.
// Options  : honours SEGMENTOS_BLANK_EN for the blank-digit expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segmentos_a_binario;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'd0;
  logic       seg_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       seg_ready;
  logic [7:0] value_out;
  logic       err_out;
  logic       ovf_out;
  logic       out_valid;

  segmentos_a_binario #(.NUM_DIGITS(3), .VALUE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .value_out (value_out),
    .err_out   (err_out),
    .ovf_out   (ovf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011, PBLANK = 7'b0000000, PBAD = 7'b0000001;

  logic [6:0] pat [10] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: look the pattern up in the legal digit list, build the
  // decimal value with integer arithmetic, then saturate at 255.
  function automatic void ref_digit(input logic [6:0] p, output int d, output bit bad);
    d = 0;
    bad = 1'b1;
    for (int i = 0; i < 10; i++) if (p == pat[i]) begin d = i; bad = 1'b0; end
`ifdef SEGMENTOS_BLANK_EN
    if (p == 7'b0000000) bad = 1'b0;
`endif
  endfunction

  function automatic void ref_frame(input logic [20:0] digs, output int val,
                                    output bit err, output bit ovf);
    int v, d;
    bit bad;
    v = 0;
    err = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      ref_digit(digs[k*7 +: 7], d, bad);
      v = v * 10 + d;
      err = err | bad;
    end
    ovf = (v > 255);
    val = ovf ? 255 : v;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic send_digit(input logic [6:0] p, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    seg_in = p;
    seg_valid = 1'b1;
    n = 0;
    while (!seg_ready && n < 50) begin @(negedge clk); n++; end
    if (!seg_ready) check("seg_ready_timeout", seg_ready, 1);
    @(negedge clk);
    seg_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int ev, input bit ee,
                            input bit eo, input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_value"}, value_out, ev);
    check({tag, "_err"}, err_out, ee);
    check({tag, "_ovf"}, ovf_out, eo);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_value"}, value_out, ev);
      check({tag, "_hold_seg_ready"}, seg_ready, 0);
      check({tag, "_hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 0);
    check({tag, "_ready_again"}, seg_ready, 1);
  endtask

  task automatic run_frame(input string tag, input logic [20:0] digs, input int gap,
                           input int hold, input int ev, input bit ee, input bit eo);
    send_digit(digs[20:14], 0);
    send_digit(digs[13:7], gap);
    check({tag, "_early_valid"}, out_valid, 0);
    send_digit(digs[6:0], gap);
    check({tag, "_latency"}, out_valid, 1);
    get_result(tag, ev, ee, eo, hold);
  endtask

  typedef struct {
    logic [20:0] digs;
    int          val;
    bit          err;
    bit          ovf;
  } vec_t;

  vec_t vt [7];
  bit   blank_err;

  initial begin
    int  rv;
    bit  re, ro;
    logic [20:0] rd;
    logic [6:0]  p;

`ifdef SEGMENTOS_BLANK_EN
    blank_err = 1'b0;
`else
    blank_err = 1'b1;
`endif
    vt[0] = '{{P1, P0, P0}, 100, 1'b0, 1'b0};
    vt[1] = '{{P2, P5, P5}, 255, 1'b0, 1'b0};
    vt[2] = '{{P2, P5, P6}, 255, 1'b0, 1'b1};
    vt[3] = '{{P9, P9, P9}, 255, 1'b0, 1'b1};
    vt[4] = '{{P1, PBAD, P3}, 103, 1'b1, 1'b0};
    vt[5] = '{{P0, P0, P0}, 0, 1'b0, 1'b0};
    vt[6] = '{{PBLANK, PBLANK, P7}, 7, blank_err, 1'b0};

    // Reset state, and seg_ready rising on the first edge after release.
    #1;
    check("rst_seg_ready", seg_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_value", value_out, 0);
    check("rst_err", err_out, 0);
    check("rst_ovf", ovf_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_ready_low", seg_ready, 0);
    @(negedge clk);
    check("rst_release_ready_high", seg_ready, 1);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vt[i].digs, 0, 0, vt[i].val, vt[i].err, vt[i].ovf);

    // Gaps of 2 cycles, result held 5 cycles with a digit offered in HOLD.
    send_digit(P1, 0);
    send_digit(P5, 2);
    send_digit(P0, 2);
    check("gap_latency", out_valid, 1);
    check("gap_value", value_out, 150);
    seg_in = P9;
    seg_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("gap_hold_value", value_out, 150);
      check("gap_hold_seg_ready", seg_ready, 0);
      check("gap_hold_valid", out_valid, 1);
    end
    seg_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("gap_released", out_valid, 0);
    check("gap_ready_again", seg_ready, 1);
    run_frame("after_hold", {P0, P4, P2}, 0, 0, 42, 1'b0, 1'b0);

    // Random frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) p = 7'($urandom);
        else p = pat[$urandom_range(0, 9)];
        rd[k*7 +: 7] = p;
      end
      ref_frame(rd, rv, re, ro);
      run_frame($sformatf("rnd%0d", f), rd, $urandom_range(0, 2),
                $urandom_range(0, 2), rv, re, ro);
    end

    // Mid-frame reset: outputs clear asynchronously, partial frame dropped.
    run_frame("pre_reset", {P8, P8, P8}, 0, 0, 255, 1'b0, 1'b1);
    send_digit(P3, 0);
    send_digit(P7, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seg_ready", seg_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_value", value_out, 0);
    check("mid_rst_err", err_out, 0);
    check("mid_rst_ovf", ovf_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frame("post_rst", {P0, P4, P2}, 0, 0, 42, 1'b0, 1'b0);

    // Reset while holding a result.
    send_digit(P1, 0);
    send_digit(P2, 0);
    send_digit(P3, 0);
    check("hold_rst_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("hold_rst_valid", out_valid, 0);
    check("hold_rst_value", value_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame("post_hold_rst", {P0, P0, P9}, 1, 1, 9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
